// File: rtl/his_peak_finder_pkg.sv
// Shared constants and FSM encoding for the histogram peak finder.
// Optional neighbour outputs are enabled with the PEAK_NBR_EN macro.
package his_peak_finder_pkg;

  localparam int NB_DEF      = 8;
  localparam int BIN_NUM_DEF = 256;
  localparam int CNT_W_DEF   = 16;
  localparam int PIX_NUM_DEF = 200;
  localparam int PIX_W_DEF   = 8;
  localparam int THRESH_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/his_peak_finder_if.sv
// Bank-read and peak-record bus of the peak finder; master = finder, slave = builder/consumer side.
// pk_left/pk_right exist only when PEAK_NBR_EN is defined.
interface his_peak_finder_if
  import his_peak_finder_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PIX_W = PIX_W_DEF
);
  logic             his_num;
  logic             rd_en;
  logic             rd_bank;
  logic [PIX_W-1:0] rd_pix;
  logic [NB-1:0]    rd_bin;
  logic [CNT_W-1:0] rd_data;
  logic             pk_valid;
  logic             pk_ready;
  logic [PIX_W-1:0] pk_pix;
  logic [NB-1:0]    pk_bin;
  logic [CNT_W-1:0] pk_cnt;
  logic             pk_hit;
  logic             frame_done;
  logic             busy;
  logic             overrun;
`ifdef PEAK_NBR_EN
  logic [CNT_W-1:0] pk_left;
  logic [CNT_W-1:0] pk_right;
`endif

  modport master (
    input  his_num, rd_data, pk_ready,
    output rd_en, rd_bank, rd_pix, rd_bin,
           pk_valid, pk_pix, pk_bin, pk_cnt, pk_hit,
`ifdef PEAK_NBR_EN
           pk_left, pk_right,
`endif
           frame_done, busy, overrun
  );

  modport slave (
    output his_num, rd_data, pk_ready,
    input  rd_en, rd_bank, rd_pix, rd_bin,
           pk_valid, pk_pix, pk_bin, pk_cnt, pk_hit,
`ifdef PEAK_NBR_EN
           pk_left, pk_right,
`endif
           frame_done, busy, overrun
  );

endinterface

// File: rtl/his_peak_finder_max_tracker.sv
// Running argmax over one pixel's bin stream; outputs include the sample presented this cycle.
// With PEAK_NBR_EN it also tracks the counts of the bins either side of the current maximum.
module his_peak_finder_max_tracker #(
  parameter int NB    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             sample_valid_i,
  input  logic [CNT_W-1:0] sample_i,
  input  logic [NB-1:0]    sample_idx_i,
`ifdef PEAK_NBR_EN
  output logic [CNT_W-1:0] left_o,
  output logic [CNT_W-1:0] right_o,
`endif
  output logic [CNT_W-1:0] max_cnt_o,
  output logic [NB-1:0]    max_idx_o
);

  logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
  logic [NB-1:0]    max_idx_q, max_idx_d;
  logic             win;

  // Strict compare so that ties keep the earliest (lowest) bin.
  always_comb begin
    win       = sample_valid_i && (sample_i > max_cnt_q);
    max_cnt_d = max_cnt_q;
    max_idx_d = max_idx_q;
    if (clear_i) begin
      max_cnt_d = '0;
      max_idx_d = '0;
    end else if (win) begin
      max_cnt_d = sample_i;
      max_idx_d = sample_idx_i;
    end
  end

  always_ff @(posedge clk) begin
    max_cnt_q <= max_cnt_d;
    max_idx_q <= max_idx_d;
  end

  assign max_cnt_o = max_cnt_d;
  assign max_idx_o = max_idx_d;

`ifdef PEAK_NBR_EN
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] right_q, right_d;
  logic             cap_q, cap_d;

  // A new maximum takes the previous sample as its left neighbour and arms a one-shot right capture.
  always_comb begin
    prev_d  = prev_q;
    left_d  = left_q;
    right_d = right_q;
    cap_d   = cap_q;
    if (clear_i) begin
      prev_d  = '0;
      left_d  = '0;
      right_d = '0;
      cap_d   = 1'b0;
    end else if (sample_valid_i) begin
      prev_d = sample_i;
      if (win) begin
        left_d  = (sample_idx_i == '0) ? '0 : prev_q;
        right_d = '0;
        cap_d   = 1'b1;
      end else if (cap_q) begin
        right_d = sample_i;
        cap_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    prev_q  <= prev_d;
    left_q  <= left_d;
    right_q <= right_d;
    cap_q   <= cap_d;
  end

  assign left_o  = left_d;
  assign right_o = right_d;
`endif

endmodule

// File: rtl/his_peak_finder.sv
// Scans each completed histogram bank and emits one argmax record per pixel over valid/ready.
// Define PEAK_NBR_EN to add pk_left/pk_right neighbour counts to each record.
module his_peak_finder
  import his_peak_finder_pkg::*;
#(
  parameter int NB      = NB_DEF,
  parameter int BIN_NUM = BIN_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PIX_NUM = PIX_NUM_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int THRESH  = THRESH_DEF
) (
  input logic             clk,
  input logic             res,
  his_peak_finder_if.master bus
);

  localparam logic [NB-1:0]    BIN_LAST = NB'(BIN_NUM - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NUM - 1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_e           state_q;
  logic             primed_q, his_num_q, pend_q, pend_bank_q, overrun_q;
  logic             rd_en_q, rd_bank_q;
  logic [PIX_W-1:0] rd_pix_q;
  logic [NB-1:0]    rd_bin_q;
  logic             vld_p1;
  logic [NB-1:0]    bin_p1;
  logic             pk_valid_q, pk_hit_q, frame_done_q;
  logic [PIX_W-1:0] pk_pix_q;
  logic [NB-1:0]    pk_bin_q;
  logic [CNT_W-1:0] pk_cnt_q;
  logic [CNT_W-1:0] max_cnt;
  logic [NB-1:0]    max_idx;
  logic             flip, start_pend, start_flip, hold_flip, trk_clear;
`ifdef PEAK_NBR_EN
  logic [CNT_W-1:0] pk_left_q, pk_right_q, nbr_left, nbr_right;
`endif

  // A flip starts a scan directly only when nothing else is queued; otherwise it is parked as pending.
  always_comb begin
    flip       = primed_q & (bus.his_num ^ his_num_q);
    start_pend = (state_q == ST_DONE) & pend_q;
    start_flip = flip & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ~pend_q));
    hold_flip  = flip & ~start_flip;
    trk_clear  = (state_q == ST_SCAN) & (rd_bin_q == '0);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= ST_IDLE;
      primed_q     <= 1'b0;
      his_num_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_bank_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_pix_q     <= '0;
      rd_bin_q     <= '0;
      vld_p1       <= 1'b0;
      pk_valid_q   <= 1'b0;
      pk_pix_q     <= '0;
      pk_bin_q     <= '0;
      pk_cnt_q     <= '0;
      pk_hit_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PEAK_NBR_EN
      pk_left_q    <= '0;
      pk_right_q   <= '0;
`endif
    end else begin
      primed_q     <= 1'b1;
      his_num_q    <= bus.his_num;
      vld_p1       <= rd_en_q;
      frame_done_q <= 1'b0;
      // A pending bank already waiting means the older one is lost, unless DONE is consuming it now.
      if (hold_flip) begin
        pend_q      <= 1'b1;
        pend_bank_q <= his_num_q;
        if (pend_q && !start_pend) overrun_q <= 1'b1;
      end else if (start_pend) begin
        pend_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_flip) begin
            state_q   <= ST_SCAN;
            rd_en_q   <= 1'b1;
            rd_bank_q <= his_num_q;
            rd_pix_q  <= '0;
            rd_bin_q  <= '0;
          end
        end
        ST_SCAN: begin
          if (rd_bin_q == BIN_LAST) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_bin_q <= rd_bin_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q    <= ST_EMIT;
          pk_valid_q <= 1'b1;
          pk_pix_q   <= rd_pix_q;
          pk_bin_q   <= max_idx;
          pk_cnt_q   <= max_cnt;
          pk_hit_q   <= (max_cnt >= THRESH_C);
`ifdef PEAK_NBR_EN
          pk_left_q  <= nbr_left;
          pk_right_q <= nbr_right;
`endif
        end
        ST_EMIT: begin
          if (bus.pk_ready) begin
            pk_valid_q <= 1'b0;
            if (rd_pix_q == PIX_LAST) begin
              state_q      <= ST_DONE;
              frame_done_q <= 1'b1;
            end else begin
              state_q  <= ST_SCAN;
              rd_en_q  <= 1'b1;
              rd_pix_q <= rd_pix_q + 1'b1;
              rd_bin_q <= '0;
            end
          end
        end
        ST_DONE: begin
          if (start_pend || start_flip) begin
            state_q   <= ST_SCAN;
            rd_en_q   <= 1'b1;
            rd_bank_q <= start_pend ? pend_bank_q : his_num_q;
            rd_pix_q  <= '0;
            rd_bin_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // p1: read data returns one cycle after the address, so the bin index is delayed to match.
  always_ff @(posedge clk) begin
    bin_p1 <= rd_bin_q;
  end

  his_peak_finder_max_tracker #(
    .NB    (NB),
    .CNT_W (CNT_W)
  ) u_max (
    .clk            (clk),
    .clear_i        (trk_clear),
    .sample_valid_i (vld_p1),
    .sample_i       (bus.rd_data),
    .sample_idx_i   (bin_p1),
`ifdef PEAK_NBR_EN
    .left_o         (nbr_left),
    .right_o        (nbr_right),
`endif
    .max_cnt_o      (max_cnt),
    .max_idx_o      (max_idx)
  );

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.rd_pix     = rd_pix_q;
  assign bus.rd_bin     = rd_bin_q;
  assign bus.pk_valid   = pk_valid_q;
  assign bus.pk_pix     = pk_pix_q;
  assign bus.pk_bin     = pk_bin_q;
  assign bus.pk_cnt     = pk_cnt_q;
  assign bus.pk_hit     = pk_hit_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.overrun    = overrun_q;
`ifdef PEAK_NBR_EN
  assign bus.pk_left    = pk_left_q;
  assign bus.pk_right   = pk_right_q;
`endif

endmodule
